// File: rtl/fp_to_posit_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fp_to_posit_pipe_pkg
// Shared IEEE-754 / posit configuration. Everything is derived from the storage
// width so that one parameter (FPWID) selects a consistent float format, posit
// exponent size and the special posit constants.
//   fp_ew / fp_emsb / fp_fmsb : float exponent width, exponent MSB, fraction MSB
//   fp_bias                   : float exponent bias
//   posit_es                  : posit exponent field width
//   posit_rsw                 : signed width for the unbiased exponent X and
//                               the regime count k (float exponent range plus
//                               subnormal normalisation shift plus one guard bit)
//   posit_nar/maxpos/minpos   : special posit patterns, MAXW bits wide; callers
//                               slice them down to their own width
// -----------------------------------------------------------------------------
package fp_to_posit_pipe_pkg;

    localparam int MAXW = 128;

    function automatic int fp_ew(input int wid);
        case (wid)
            16:      return 5;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    function automatic int fp_emsb(input int wid);
        return fp_ew(wid) - 1;
    endfunction

    function automatic int fp_fmsb(input int wid);
        return wid - fp_ew(wid) - 2;
    endfunction

    function automatic int fp_bias(input int wid);
        return (1 << (fp_ew(wid) - 1)) - 1;
    endfunction

    function automatic int posit_es(input int wid);
        case (wid)
            16:      return 1;
            64:      return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int posit_rsw(input int wid);
        return fp_ew(wid) + 2;
    endfunction

    function automatic logic [MAXW-1:0] posit_nar(input int wid);
        return MAXW'(1) << (wid - 1);
    endfunction

    function automatic logic [MAXW-1:0] posit_maxpos(input int wid);
        return (MAXW'(1) << (wid - 1)) - MAXW'(1);
    endfunction

    function automatic logic [MAXW-1:0] posit_minpos(input int wid);
        return MAXW'(1) + MAXW'(wid - wid);
    endfunction

endpackage

// File: rtl/cntlz.sv
// -----------------------------------------------------------------------------
// cntlz
// Combinational leading-zero counter.
//   i : operand
//   o : number of leading zeros in i (WID when i is all zeros)
// -----------------------------------------------------------------------------
module cntlz #(
    parameter int WID = 23,
    parameter int CW  = $clog2(WID + 1)
) (
    input  logic [WID-1:0] i,
    output logic [CW-1:0]  o
);

    always_comb begin
        // NOTE: default assigned before the loop so every path writes o and no latch is inferred.
        o = CW'(WID);
        // Ascending scan: the last hit is the most significant set bit.
        for (int b = 0; b < WID; b++) begin
            if (i[b]) o = CW'(WID - 1 - b);
        end
    end

endmodule

// File: rtl/posit_round_pack.sv
// -----------------------------------------------------------------------------
// posit_round_pack
// Combinational posit packer: builds regime, exponent and fraction, rounds to
// nearest-even on the bits beyond WID, saturates to maxpos/minpos and applies
// the sign as a two's complement.
//   sign   : operand sign
//   k      : regime count (signed)
//   expo   : posit exponent field
//   frac   : fraction bits below the hidden one
//   sticky : OR of any fraction bits already discarded upstream
//   o      : rounded posit
// -----------------------------------------------------------------------------
module posit_round_pack
    import fp_to_posit_pipe_pkg::*;
#(
    parameter int WID = 32,
    parameter int ES  = 2,
    parameter int FW  = 23,
    parameter int KW  = 10
) (
    input  logic                 sign,
    input  logic signed [KW-1:0] k,
    input  logic [ES-1:0]        expo,
    input  logic [FW-1:0]        frac,
    input  logic                 sticky,
    output logic [WID-1:0]       o
);

    localparam int VW = 2 + ES + FW + WID;      // seed plus room for the longest in-range shift
    localparam int GB = VW - WID;               // guard bit position
    localparam logic signed [KW-1:0] K_MAX = KW'(WID - 2);
    localparam logic signed [KW-1:0] K_MIN = KW'(2 - WID);
    localparam logic [MAXW-1:0] MAXPOS_W = posit_maxpos(WID);
    localparam logic [MAXW-1:0] MINPOS_W = posit_minpos(WID);
    localparam logic [WID-2:0] MAXPOS = MAXPOS_W[WID-2:0];
    localparam logic [WID-2:0] MINPOS = MINPOS_W[WID-2:0];

    logic signed [VW-1:0] seed;
    logic signed [VW-1:0] body;
    logic [KW-1:0]        sh;
    logic [WID-2:0]       field;
    logic [WID-2:0]       mag;
    logic [WID-1:0]       sum;
    logic                 guard;
    logic                 sticky_all;
    logic                 up;

    always_comb begin
        // The two seed bits become the regime after an arithmetic shift:
        // '10' shifted by k smears into k+1 ones and a zero; '01' shifted by
        // -k-1 (= ~k) gives -k zeros followed by a one.
        seed       = {k[KW-1] ? 2'b01 : 2'b10, expo, frac, {WID{1'b0}}};
        sh         = k[KW-1] ? ~k : k;
        body       = seed >>> sh;
        field      = body[VW-1 -: WID-1];
        guard      = body[GB];
        sticky_all = (|body[GB-1:0]) | sticky;
        up         = guard & (field[0] | sticky_all);
        sum        = {1'b0, field} + {{(WID-1){1'b0}}, up};
        if (k >= K_MAX) begin
            mag = MAXPOS;
        end else if (k < K_MIN) begin
            mag = MINPOS;
        end else if (sum[WID-1]) begin
            mag = MAXPOS;                       // rounding carried past maxpos
        end else begin
            mag = sum[WID-2:0];
        end
        o = sign ? -{1'b0, mag} : {1'b0, mag};
    end

endmodule

// File: rtl/fp_to_posit_pipe.sv
// -----------------------------------------------------------------------------
// fp_to_posit_pipe
// Three-stage IEEE-754 to posit converter with valid/ready handshaking.
//   S1 unpack and classify, S2 normalise and split exponent into regime and
//   posit exponent, S3 pack/round into the output register.
//   clk, rst_n       : clock, synchronous active-low reset
//   i_valid, i_ready : input handshake (i_ready = pipeline may advance)
//   i                : IEEE-754 operand
//   o_valid, o_ready : output handshake
//   o                : posit result
// -----------------------------------------------------------------------------
module fp_to_posit_pipe #(
    parameter int FPWID = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [FPWID-1:0] i,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [FPWID-1:0] o
);
    import fp_to_posit_pipe_pkg::*;

    localparam int ES   = posit_es(FPWID);
    localparam int EMSB = fp_emsb(FPWID);
    localparam int FMSB = fp_fmsb(FPWID);
    localparam int BIAS = fp_bias(FPWID);
    localparam int XW   = posit_rsw(FPWID);
    localparam int LZW  = $clog2(FMSB + 2);
    localparam logic [MAXW-1:0]      NAR_W  = posit_nar(FPWID);
    localparam logic [FPWID-1:0]     NAR    = NAR_W[FPWID-1:0];
    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);

    logic                 en;
    logic                 s1_v, s1_sign, s1_zero, s1_sub, s1_nar;
    logic [EMSB:0]        s1_exp;
    logic [FMSB:0]        s1_frac;
    logic [LZW-1:0]       lz;
    logic signed [XW-1:0] exp_x, lz_x, x;
    logic                 s2_v, s2_sign, s2_zero, s2_nar;
    logic signed [XW-1:0] s2_k;
    logic [ES-1:0]        s2_ex;
    logic [FMSB:0]        s2_frac;
    logic [FPWID-1:0]     pack_o, s3_o;

    // One enable for the whole pipe: it moves whenever the output slot is free
    // or being drained, so a stall freezes every stage together.
    assign en      = ~o_valid | o_ready;
    assign i_ready = en;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            o_valid <= 1'b0;
            o       <= '0;
        end else if (en) begin
            s1_v    <= i_valid;
            s2_v    <= s1_v;
            o_valid <= s2_v;
            o       <= s3_o;
        end
    end

    // NOTE: stage data registers have no reset; their contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign <= i[FPWID-1];
            s1_exp  <= i[FPWID-2 -: EMSB+1];
            s1_frac <= i[FMSB:0];
            s1_zero <= ~|i[FPWID-2:0];
            s1_sub  <= (~|i[FPWID-2 -: EMSB+1]) & (|i[FMSB:0]);
            s1_nar  <= &i[FPWID-2 -: EMSB+1];
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_nar  <= s1_nar;
            s2_k    <= x >>> ES;
            s2_ex   <= x[ES-1:0];
            // Shift past the leading one so it becomes the implicit bit.
            s2_frac <= s1_sub ? (s1_frac << lz) << 1 : s1_frac;
        end
    end

    cntlz #(
        .WID (FMSB + 1)
    ) u_lz (
        .i (s1_frac),
        .o (lz)
    );

    // A subnormal 0.f * 2^(1-BIAS) normalises to 1.f' * 2^(-BIAS-lz).
    assign exp_x = {{(XW-EMSB-1){1'b0}}, s1_exp};
    assign lz_x  = {{(XW-LZW){1'b0}}, lz};
    assign x     = s1_sub ? -BIAS_X - lz_x : exp_x - BIAS_X;

    posit_round_pack #(
        .WID (FPWID),
        .ES  (ES),
        .FW  (FMSB + 1),
        .KW  (XW)
    ) u_pack (
        .sign   (s2_sign),
        .k      (s2_k),
        .expo   (s2_ex),
        .frac   (s2_frac),
        .sticky (1'b0),
        .o      (pack_o)
    );

    assign s3_o = s2_nar ? NAR : (s2_zero ? '0 : pack_o);

endmodule

// File: tb/tb_fp_to_posit_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_to_posit_pipe
// Self-checking bench for fp_to_posit_pipe (FPWID=32, es=2). Expected results
// come from fixed vectors and from a bit-string posit encoder model.
// -----------------------------------------------------------------------------
module tb_fp_to_posit_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready = 1'b1;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] i = '0;
    logic [31:0] o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] acc_q[$];
    logic [31:0] out_q[$];
    int          acc_cyc[$];
    int          out_cyc[$];

    fp_to_posit_pipe #(.FPWID(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i       (i),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o       (o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- reference model: posit<32,2> from IEEE-754 single ----
    function automatic logic [31:0] model(input logic [31:0] f);
        int          e, x, k, ex;
        logic [23:0] m;
        bit          q[$];
        logic [31:0] field, mag;
        bit          guard, sticky;
        e = int'(f[30:23]);
        if (e == 255) return 32'h8000_0000;
        if (e == 0 && f[22:0] == 23'd0) return 32'h0;
        if (e == 0) begin
            x = -126;
            m = {1'b0, f[22:0]};
            while (!m[23]) begin
                m = m << 1;
                x--;
            end
        end else begin
            x = e - 127;
            m = {1'b1, f[22:0]};
        end
        k  = (x >= 0) ? x / 4 : -((3 - x) / 4);   // floor(x / 2^es)
        ex = x - 4 * k;
        if (k >= 0) begin
            repeat (k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            repeat (-k) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        q.push_back(ex[1]);
        q.push_back(ex[0]);
        for (int b = 22; b >= 0; b--) q.push_back(m[b]);
        while (q.size() < 33) q.push_back(1'b0);
        field = 32'h0;
        for (int b = 0; b < 31; b++) field = {field[30:0], q[b]};
        guard  = q[31];
        sticky = 1'b0;
        for (int b = 32; b < q.size(); b++) sticky |= q[b];
        mag = field + ((guard && (field[0] || sticky)) ? 32'd1 : 32'd0);
        if (mag[31] || k >= 30) mag = 32'h7FFF_FFFF;
        if (mag == 32'h0 || k < -30) mag = 32'h1;
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0:       ;
            1:       v[30:23] = 8'($urandom_range(100, 154));
            2:       v[30:23] = 8'($urandom_range(0, 3));
            default: v[30:23] = 8'($urandom_range(112, 140));
        endcase
        return v;
    endfunction

    // ---------------- stimulus plumbing ------------------------------------
    task automatic clear_q();
        acc_q.delete(); acc_cyc.delete();
        out_q.delete(); out_cyc.delete();
    endtask

    task automatic record();
        if (i_valid && i_ready) begin acc_q.push_back(i); acc_cyc.push_back(cyc); end
        if (o_valid && o_ready) begin out_q.push_back(o); out_cyc.push_back(cyc); end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        record();
        step();
    endtask

    task automatic stream(input logic [31:0] ops[$]);
        clear_q();
        o_ready = 1'b1;
        foreach (ops[j]) begin
            i_valid = 1'b1;
            i       = ops[j];
            tick();
        end
        i_valid = 1'b0;
        for (int t = 0; t < 20 && out_q.size() < ops.size(); t++) tick();
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o !== 32'h0) begin n_fail++; $display("FAIL reset_o: got %08h want 00000000", o); end
        n_checks++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] ops[$] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h3F00_0000};
        logic [31:0] exp[$] = '{32'h4000_0000, 32'hC000_0000, 32'h4800_0000, 32'h3800_0000};
        stream(ops);
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d want %0d", out_q.size(), exp.size());
        end
        for (int j = 0; j < out_q.size() && j < exp.size(); j++) begin
            n_checks++;
            if (out_q[j] !== exp[j]) begin
                n_fail++; $display("FAIL basic[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], exp[j]);
            end
            n_checks++;
            if (out_cyc[j] - acc_cyc[j] != 3) begin
                n_fail++; $display("FAIL basic_latency[%0d]: got %0d want 3", j, out_cyc[j] - acc_cyc[j]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] ops[$] = '{32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h0000_0000};
        logic [31:0] exp[$] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        stream(ops);
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL specials_count: got %0d want %0d", out_q.size(), exp.size());
        end
        for (int j = 0; j < out_q.size() && j < exp.size(); j++) begin
            n_checks++;
            if (out_q[j] !== exp[j]) begin
                n_fail++; $display("FAIL specials[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], exp[j]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] ops[$] = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h0000_0001, 32'h8000_0001};
        logic [31:0] exp[$] = '{32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        stream(ops);
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL saturation_count: got %0d want %0d", out_q.size(), exp.size());
        end
        for (int j = 0; j < out_q.size() && j < exp.size(); j++) begin
            n_checks++;
            if (out_q[j] !== exp[j]) begin
                n_fail++; $display("FAIL saturation[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], exp[j]);
            end
        end
    endtask

    // 2^24 * 1.f: regime takes 8 bits, so the two lowest fraction bits drop.
    task automatic test_rounding_tie();
        logic [31:0] ops[$] = '{32'h4B80_0002, 32'h4B80_0006, 32'hCB80_0002, 32'hCB80_0006};
        logic [31:0] exp[$] = '{32'h7F00_0000, 32'h7F00_0002, 32'h8100_0000, 32'h80FF_FFFE};
        stream(ops);
        n_checks++;
        if (out_q.size() != ops.size()) begin
            n_fail++; $display("FAIL tie_count: got %0d want %0d", out_q.size(), ops.size());
        end
        for (int j = 0; j < out_q.size() && j < ops.size(); j++) begin
            n_checks++;
            if (out_q[j] !== exp[j]) begin
                n_fail++; $display("FAIL tie[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], exp[j]);
            end
            n_checks++;
            if (out_q[j] !== model(ops[j])) begin
                n_fail++; $display("FAIL tie_model[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], model(ops[j]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops[$];
        for (int j = 0; j < 40; j++) ops.push_back(rand_op());
        stream(ops);
        n_checks++;
        if (out_q.size() != ops.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d want %0d", out_q.size(), ops.size());
        end
        for (int j = 0; j < out_q.size() && j < ops.size(); j++) begin
            n_checks++;
            if (out_q[j] !== model(ops[j])) begin
                n_fail++; $display("FAIL b2b[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], model(ops[j]));
            end
            n_checks++;
            if (out_cyc[j] != out_cyc[0] + j || out_cyc[j] - acc_cyc[j] != 3) begin
                n_fail++; $display("FAIL b2b_timing[%0d]: out cycle %0d accept cycle %0d first out %0d", j, out_cyc[j], acc_cyc[j], out_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ops[$];
        logic [31:0] held_o;
        bit          held;
        int          idx;
        for (int j = 0; j < 10; j++) ops.push_back(rand_op());
        clear_q();
        idx  = 0;
        held = 1'b0;
        held_o = '0;
        for (int t = 0; t < 60 && out_q.size() < 10; t++) begin
            i_valid = (idx < 10);
            i       = (idx < 10) ? ops[idx] : 32'h0;
            o_ready = !(t >= 5 && t < 9);
            @(negedge clk);
            n_checks++;
            if (i_ready !== !(o_valid && !o_ready)) begin
                n_fail++; $display("FAIL bp_i_ready[t=%0d]: got %b want %b", t, i_ready, !(o_valid && !o_ready));
            end
            if (o_valid && !o_ready) begin
                if (held) begin
                    n_checks++;
                    if (o !== held_o) begin
                        n_fail++; $display("FAIL bp_hold[t=%0d]: got %08h want %08h", t, o, held_o);
                    end
                end
                held   = 1'b1;
                held_o = o;
            end else begin
                held = 1'b0;
            end
            if (i_valid && i_ready) idx++;
            record();
            step();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        n_checks++;
        if (out_q.size() != 10) begin
            n_fail++; $display("FAIL bp_count: got %0d want 10", out_q.size());
        end
        for (int j = 0; j < out_q.size() && j < 10; j++) begin
            n_checks++;
            if (out_q[j] !== model(ops[j])) begin
                n_fail++; $display("FAIL bp[%0d]: in %08h got %08h want %08h", j, ops[j], out_q[j], model(ops[j]));
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        o_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            i_valid = 1'b1;
            i       = rand_op();
            tick();
        end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_o_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o !== 32'h0) begin n_fail++; $display("FAIL midreset_o: got %08h want 00000000", o); end
        o_ready = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        n_checks++;
        if (acc_q.size() != 3) begin n_fail++; $display("FAIL midreset_accepts: got %0d want 3", acc_q.size()); end
        n_checks++;
        if (out_q.size() != 0) begin n_fail++; $display("FAIL midreset_leak: got %0d results want 0", out_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_saturation();
        test_rounding_tie();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
